mem_bus_master: RTL
===================

Name: mem_bus_master

Overview:
- CPU-side initiator for the memory-space bus. Accepts one read or write request at a time from the execution unit, drives MAB/MDB/MW/BW to the memory-space decoder, and waits for write completion.
- Performs byte-lane extraction on read data and returns a single response per request.
- Flags accesses to the unused address hole as errors without issuing a bus cycle.

Parameters:
- UNUSED_LO, 16'h0400, first address of unused region (inclusive)
- UNUSED_HI, 16'hC000, end of unused region (exclusive); ROM starts here
- WR_TIMEOUT, 15, maximum cycles in WR_WAIT before the write aborts with error
- TCW, 4, timeout counter width; must satisfy 2**TCW > WR_TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept a request (high only in IDLE)
- req_we  in  1  1=write, 0=read
- req_bw  in  1  1=byte access, 0=word access
- req_addr  in  16  byte address
- req_wdata  in  16  write data; byte writes use [7:0]
- rsp_valid  out  1  one-cycle pulse, response valid
- rsp_rdata  out  16  read data (0 for writes and errors)
- rsp_err  out  1  qualified by rsp_valid
- MAB  out  16  memory address bus
- MDB_wr  out  16  write data to memory (memory-side MDB_in)
- MW  out  1  memory write strobe
- BW  out  1  byte access flag
- MDB_rd  in  16  read data from memory (memory-side MDB_out)
- ram_write_done  in  1  write-complete acknowledge from RAM

Behaviour:
- Reset (async, rst_n low) values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, MAB=0, MDB_wr=0, MW=0, BW=0, timeout count=0.
- Reset asserted mid-operation abandons the access immediately, drops MW, and returns to IDLE. No response is generated for the abandoned access.
- Handshake: a request is accepted when req_valid && req_ready at a clock edge. Request fields are registered at acceptance, so inputs may change afterwards.
- Address formation:
  - Word access: MAB = {req_addr[15:1],1'b0} (LSB forced to 0).
  - Byte access: MAB = req_addr.
- Error check at acceptance: UNUSED_LO <= addr < UNUSED_HI goes to RESP with err=1 and rdata=0. MAB/MW stay untouched and no bus cycle is issued.
- FSM states: IDLE, RD, WR, WR_WAIT, RESP.
  - IDLE: on accept, go to RD (read), WR (write), or RESP (error).
  - RD: MAB and BW driven for exactly one cycle. At the end of the cycle, sample MDB_rd and go to RESP.
  - Read data formatting:
    - Word read: rdata = MDB_rd.
    - Byte read: rdata = {8'h00, addr[0] ? MDB_rd[15:8] : MDB_rd[7:0]}.
  - WR: drive MAB, BW, MW=1, and MDB_wr.
    - MDB_wr = req_wdata for a word write.
    - MDB_wr = {wdata[7:0], wdata[7:0]} for a byte write.
    - Clear the timeout count and go to WR_WAIT.
  - WR_WAIT: hold MW=1 and all bus outputs stable. Increment the count each cycle.
    - ram_write_done=1: drop MW next cycle, go to RESP with err=0.
    - Count reaches WR_TIMEOUT without done: drop MW, go to RESP with err=1.
    - ram_write_done sampled in the same cycle the count hits WR_TIMEOUT: treated as success.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- Latency:
  - Read: response 2 cycles after acceptance.
  - Error: response 1 cycle after acceptance.
  - Write: response 2 cycles plus wait cycles.
- Throughput: req_ready is 0 in every state except IDLE, so at most one outstanding request.
- ram_write_done outside WR_WAIT is ignored.
- MW is never high outside WR/WR_WAIT, and MW=0 during RD.
- rsp_rdata and rsp_err hold their values until the next RESP; they are meaningful only with rsp_valid.

Optional Feature:
- Macro: MEM_BUS_ROM_WP_EN
- Defined: any write with addr >= UNUSED_HI (ROM/IVT) is rejected at acceptance like an unused-region access. Goes to RESP with err=1; MW never asserts.
- Undefined: ROM writes are issued normally (MW pulses) and complete via ram_write_done or timeout.

Test Plan:
- Word read 0x0201; memory returns 16'hBEEF at MAB 0x0200 -> MAB=0x0200, MW=0, rsp_valid 2 cycles after accept, rsp_rdata=16'hBEEF, err=0.
- Byte read 0x0203 with MDB_rd=16'h12AB -> BW=1, MAB=0x0203, rsp_rdata=16'h0012.
- Byte write 0x0210, wdata=16'h3456; ram_write_done after 3 cycles -> MDB_wr=16'h5656, MW high exactly through the done cycle, rsp_err=0.
- Write to 0x0300 with ram_write_done held 0 -> MW high for WR_TIMEOUT+1 cycles, then rsp_valid with rsp_err=1, MW=0.
- Read 0x8000 -> no MAB change, no MW, rsp_valid 1 cycle after accept, rsp_err=1, rdata=0. Repeat with a write to 0xC010 under both macro settings and check the error vs. issued behaviour.
- Assert rst_n low during WR_WAIT -> MW=0 and req_ready=1 immediately; no rsp_valid afterwards; the next read completes normally.

Source files
------------

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the memory-space bus: one request at a time, unused-hole rejection, write timeout.
// Optional define MEM_BUS_ROM_WP_EN rejects writes at or above UNUSED_HI (ROM/IVT write protection).
module mem_bus_master #(
   parameter logic [15:0] UNUSED_LO  = 16'h0400,
   parameter logic [15:0] UNUSED_HI  = 16'hC000,
   parameter int unsigned WR_TIMEOUT = 15,
   parameter int unsigned TCW        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_bw,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] MAB,
   output logic [15:0] MDB_wr,
   output logic        MW,
   output logic        BW,
   input  logic [15:0] MDB_rd,
   input  logic        ram_write_done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      WR      = 3'd2,
      WR_WAIT = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t           state_r, state_nx_s;
   logic [15:0]      mab_r, mab_nx_s;
   logic [15:0]      mdb_wr_r, mdb_wr_nx_s;
   logic             mw_r, mw_nx_s;
   logic             bw_r, bw_nx_s;
   logic [TCW-1:0]   cnt_r, cnt_nx_s, cnt_inc_s;
   logic [15:0]      rdata_r, rdata_nx_s;
   logic             err_r, err_nx_s;
   logic             rsp_valid_r;
   logic             req_ready_r;
   logic             bad_addr_s;

   assign cnt_inc_s = cnt_r + TCW'(1);

   // Reject accesses to the unused hole (and ROM writes when write protection is built in).
   always_comb begin
      bad_addr_s = (req_addr >= UNUSED_LO) && (req_addr < UNUSED_HI);
`ifdef MEM_BUS_ROM_WP_EN
      if (req_we && (req_addr >= UNUSED_HI)) begin
         bad_addr_s = 1'b1;
      end else begin
         bad_addr_s = bad_addr_s;
      end
`endif
   end

   // Next-state and next-value logic for the FSM and its registered bus/response outputs.
   always_comb begin
      state_nx_s  = state_r;
      mab_nx_s    = mab_r;
      mdb_wr_nx_s = mdb_wr_r;
      mw_nx_s     = mw_r;
      bw_nx_s     = bw_r;
      cnt_nx_s    = cnt_r;
      rdata_nx_s  = rdata_r;
      err_nx_s    = err_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (bad_addr_s) begin
                  state_nx_s = RESP;
                  rdata_nx_s = 16'h0000;
                  err_nx_s   = 1'b1;
               end else begin
                  mab_nx_s = req_bw ? req_addr : {req_addr[15:1], 1'b0};
                  bw_nx_s  = req_bw;
                  if (req_we) begin
                     state_nx_s  = WR;
                     mw_nx_s     = 1'b1;
                     mdb_wr_nx_s = req_bw ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
                  end else begin
                     state_nx_s = RD;
                  end
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         RD: begin
            // MAB[0] equals the request's addr[0] for byte accesses.
            if (bw_r) begin
               rdata_nx_s = {8'h00, (mab_r[0] ? MDB_rd[15:8] : MDB_rd[7:0])};
            end else begin
               rdata_nx_s = MDB_rd;
            end
            err_nx_s   = 1'b0;
            state_nx_s = RESP;
         end
         WR: begin
            cnt_nx_s   = {TCW{1'b0}};
            state_nx_s = WR_WAIT;
         end
         WR_WAIT: begin
            // Done wins over a simultaneous timeout.
            if (ram_write_done) begin
               mw_nx_s    = 1'b0;
               rdata_nx_s = 16'h0000;
               err_nx_s   = 1'b0;
               state_nx_s = RESP;
            end else if (cnt_inc_s == TCW'(WR_TIMEOUT)) begin
               mw_nx_s    = 1'b0;
               rdata_nx_s = 16'h0000;
               err_nx_s   = 1'b1;
               state_nx_s = RESP;
            end else begin
               cnt_nx_s = cnt_inc_s;
            end
         end
         RESP: begin
            state_nx_s = IDLE;
         end
         default: begin
            mw_nx_s    = 1'b0;
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mab_r       <= 16'h0000;
         mdb_wr_r    <= 16'h0000;
         mw_r        <= 1'b0;
         bw_r        <= 1'b0;
         cnt_r       <= {TCW{1'b0}};
         rdata_r     <= 16'h0000;
         err_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         req_ready_r <= 1'b1;
      end else begin
         state_r     <= state_nx_s;
         mab_r       <= mab_nx_s;
         mdb_wr_r    <= mdb_wr_nx_s;
         mw_r        <= mw_nx_s;
         bw_r        <= bw_nx_s;
         cnt_r       <= cnt_nx_s;
         rdata_r     <= rdata_nx_s;
         err_r       <= err_nx_s;
         rsp_valid_r <= (state_nx_s == RESP);
         req_ready_r <= (state_nx_s == IDLE);
      end
   end

   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rdata_r;
   assign rsp_err   = err_r;
   assign MAB       = mab_r;
   assign MDB_wr    = mdb_wr_r;
   assign MW        = mw_r;
   assign BW        = bw_r;

endmodule
